// File: rtl/usb_pkg.sv
// Shared USB line/packet definitions: line states, receiver FSM states, PID classes
// and CRC polynomials/seeds/residues. Intended for both the RX deserialiser and the TX serialiser.
package usb_pkg;

    typedef enum logic [1:0] {
        LINE_J   = 2'd0,
        LINE_K   = 2'd1,
        LINE_SE0 = 2'd2,
        LINE_SE1 = 2'd3
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_t;

    localparam logic [1:0] PID_CLASS_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
    localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_CLASS_DATA      = 2'b11;

    localparam int          CRC5_W       = 5;
    localparam logic [4:0]  CRC5_POLY    = 5'h05;
    localparam logic [4:0]  CRC5_INIT    = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUE = 5'b01100;

    localparam int          CRC16_W       = 16;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    // J/K polarity swaps between full and low speed; SE0/SE1 are speed independent.
    function automatic line_t decode_line(input logic dp, input logic dm, input logic low_speed);
        line_t l;
        case ({dp, dm})
            2'b00:   l = LINE_SE0;
            2'b11:   l = LINE_SE1;
            2'b10:   l = low_speed ? LINE_K : LINE_J;
            default: l = low_speed ? LINE_J : LINE_K;
        endcase
        return l;
    endfunction

    function automatic logic pid_check_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC register (MSB-feedback form). Fed LSB-first with the received field
// including the transmitted CRC, the register ends at the polynomial's fixed residue.
module usb_crc_serial #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] crc
);

    logic [W-1:0] crc_reg;
    logic [W-1:0] crc_next;
    logic         fb;

    assign fb          = din ^ crc_reg[W-1];
    assign crc_next[0] = fb & POLY[0];

    for (genvar gi = 1; gi < W; gi++) begin : g_tap
        assign crc_next[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= INIT;
        end else if (clr) begin
            crc_reg <= INIT;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/usb_rx_deser.sv
// USB receive deserialiser: line-state decode, NRZI, SYNC/EOP detection, bit unstuffing,
// byte assembly and CRC5/CRC16 residue check at end of packet.
module usb_rx_deser
    import usb_pkg::*;
#(
    parameter bit LOW_SPEED      = 1'b0,
    parameter int SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       dp_i,
    input  logic       dm_i,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_crc_ok,
    output logic       rx_err
);

    localparam logic [3:0] SYNC_MIN = 4'(SYNC_MIN_ZEROS);

    rx_state_t   state_reg, state_next;
    line_t       prev_reg, prev_next;
    logic [3:0]  zero_cnt_reg, zero_cnt_next;
    logic [2:0]  ones_cnt_reg, ones_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  byte_cnt_reg, byte_cnt_next;
    logic [6:0]  shift_reg, shift_next;
    logic [7:0]  pid_reg, pid_next;
    logic [1:0]  se0_cnt_reg, se0_cnt_next;
    logic        align_err_reg, align_err_next;

    logic        rx_active_reg, rx_active_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        rx_valid_reg, rx_valid_next;
    logic        rx_eop_reg, rx_eop_next;
    logic        rx_crc_ok_reg, rx_crc_ok_next;
    logic        rx_err_reg, rx_err_next;

    logic        crc_clr, crc_en;
    logic [4:0]  crc5;
    logic [15:0] crc16;

    line_t       line;
    logic        is_jk, nrzi_bit, stuff_slot;
    logic        class_ok, crc_ok_calc;

    assign line       = decode_line(dp_i, dm_i, LOW_SPEED);
    assign is_jk      = (line == LINE_J) || (line == LINE_K);
    assign nrzi_bit   = (line == prev_reg);
    assign stuff_slot = (ones_cnt_reg == 3'd6);

    always_comb begin
        class_ok = 1'b0;
        case (pid_reg[1:0])
            PID_CLASS_TOKEN, PID_CLASS_SPECIAL:
                class_ok = (crc5 == CRC5_RESIDUE) && (byte_cnt_reg == 8'd3);
            PID_CLASS_DATA:
                class_ok = (crc16 == CRC16_RESIDUE) && (byte_cnt_reg >= 8'd3);
            default:
                class_ok = (byte_cnt_reg == 8'd1);
        endcase
        crc_ok_calc = (byte_cnt_reg != 8'd0) && pid_check_ok(pid_reg) && class_ok;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (bit_en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (line == LINE_K) state_next = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!is_jk)        state_next = ST_ERR;
                    else if (nrzi_bit) state_next = (zero_cnt_reg >= SYNC_MIN) ? ST_DATA : ST_ERR;
                end
                ST_DATA: begin
                    if (line == LINE_SE1)            state_next = ST_ERR;
                    else if (line == LINE_SE0)       state_next = ST_EOP;
                    else if (stuff_slot && nrzi_bit) state_next = ST_ERR;
                end
                ST_EOP: begin
                    if (line == LINE_J)                                state_next = ST_IDLE;
                    else if (line != LINE_SE0 || se0_cnt_reg == 2'd2) state_next = ST_ERR;
                end
                ST_ERR: begin
                    if (line == LINE_J) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        prev_next      = prev_reg;
        zero_cnt_next  = zero_cnt_reg;
        ones_cnt_next  = ones_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        shift_next     = shift_reg;
        pid_next       = pid_reg;
        se0_cnt_next   = se0_cnt_reg;
        align_err_next = align_err_reg;
        rx_active_next = rx_active_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        rx_eop_next    = 1'b0;
        rx_crc_ok_next = 1'b0;
        rx_err_next    = 1'b0;
        crc_clr        = 1'b0;
        crc_en         = 1'b0;

        if (bit_en) begin
            if (is_jk) prev_next = line;

            // Only the transition into ERR pulses, so each bad packet reports once.
            if (state_next == ST_ERR && state_reg != ST_ERR) begin
                rx_err_next    = 1'b1;
                rx_active_next = 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (line == LINE_K) zero_cnt_next = 4'd1;
                end
                ST_SYNC: begin
                    if (is_jk && !nrzi_bit && zero_cnt_reg != 4'hF)
                        zero_cnt_next = zero_cnt_reg + 4'd1;
                    if (state_next == ST_DATA) begin
                        rx_active_next = 1'b1;
                        ones_cnt_next  = 3'd1;
                        bit_cnt_next   = 3'd0;
                        byte_cnt_next  = 8'd0;
                        crc_clr        = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (line == LINE_SE0) begin
                        se0_cnt_next   = 2'd1;
                        align_err_next = (bit_cnt_reg != 3'd0);
                    end else if (is_jk && stuff_slot) begin
                        ones_cnt_next = 3'd0;
                    end else if (is_jk) begin
                        ones_cnt_next = nrzi_bit ? ones_cnt_reg + 3'd1 : 3'd0;
                        shift_next    = {nrzi_bit, shift_reg[6:1]};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        crc_en        = (byte_cnt_reg != 8'd0);
                        if (bit_cnt_reg == 3'd7) begin
                            rx_data_next  = {nrzi_bit, shift_reg};
                            rx_valid_next = 1'b1;
                            if (byte_cnt_reg == 8'd0)  pid_next      = {nrzi_bit, shift_reg};
                            if (byte_cnt_reg != 8'hFF) byte_cnt_next = byte_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_EOP: begin
                    if (line == LINE_SE0 && se0_cnt_reg != 2'd2) begin
                        se0_cnt_next = se0_cnt_reg + 2'd1;
                    end else if (line == LINE_J) begin
                        rx_eop_next    = 1'b1;
                        rx_crc_ok_next = crc_ok_calc;
                        rx_err_next    = align_err_reg;
                        rx_active_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg      <= LINE_J;
            zero_cnt_reg  <= '0;
            ones_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            shift_reg     <= '0;
            pid_reg       <= '0;
            se0_cnt_reg   <= '0;
            align_err_reg <= 1'b0;
            rx_active_reg <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            rx_eop_reg    <= 1'b0;
            rx_crc_ok_reg <= 1'b0;
            rx_err_reg    <= 1'b0;
        end else begin
            prev_reg      <= prev_next;
            zero_cnt_reg  <= zero_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            shift_reg     <= shift_next;
            pid_reg       <= pid_next;
            se0_cnt_reg   <= se0_cnt_next;
            align_err_reg <= align_err_next;
            rx_active_reg <= rx_active_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            rx_eop_reg    <= rx_eop_next;
            rx_crc_ok_reg <= rx_crc_ok_next;
            rx_err_reg    <= rx_err_next;
        end
    end

    usb_crc_serial #(.W(CRC5_W), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (nrzi_bit),
        .crc   (crc5)
    );

    usb_crc_serial #(.W(CRC16_W), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (nrzi_bit),
        .crc   (crc16)
    );

    assign rx_active = rx_active_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_eop    = rx_eop_reg;
    assign rx_crc_ok = rx_crc_ok_reg;
    assign rx_err    = rx_err_reg;

endmodule
